dmem_access_ctrl: RTL and testbench



---
 rtl/dmem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage: sequences load, store and
// read-modify-write accesses to a word-addressed synchronous-read memory,
// extends load results and flags illegal requests.
module dmem_access_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic                req_load,
   input  logic                req_store,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W+1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                busy,
   output logic                done,
   output logic                load_valid,
   output logic [DATA_W-1:0]   load_data,
   output logic                access_err,
   output logic                memwrite_enable,
   output logic                memread_enable,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W-1:0]   write_data,
   input  logic [DATA_W-1:0]   read_data
);

   localparam int unsigned BA_W = ADDR_W + 2;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIN} state_t;

   state_t              state, state_n;
   logic [1:0]          off_q, off_n;
   logic [1:0]          size_q, size_n;
   logic                uns_q, uns_n;
   logic                load_q, load_n;
   logic [DATA_W-1:0]   wdata_q, wdata_n;

   logic                busy_n, done_n, load_valid_n, access_err_n;
   logic                memwrite_n, memread_n;
   logic [ADDR_W-1:0]   address_n;
   logic [DATA_W-1:0]   write_data_n, load_data_n;

   logic                req_illegal;
   logic [7:0]          rd_byte;
   logic [15:0]         rd_half;
   logic [DATA_W-1:0]   ext_data;
   logic [DATA_W-1:0]   merge_data;

   // Request legality: exactly one of load/store, legal size, natural alignment
   always_comb begin
      req_illegal = (req_load == req_store)
                 || (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   // Lane extraction/extension of the read word and sub-word store merge
   always_comb begin
      rd_byte    = read_data[{off_q, 3'b000} +: 8];
      rd_half    = off_q[1] ? read_data[31:16] : read_data[15:0];
      merge_data = read_data;
      case (size_q)
         2'b00:   ext_data = uns_q ? {{(DATA_W-8){1'b0}}, rd_byte}
                                   : {{(DATA_W-8){rd_byte[7]}}, rd_byte};
         2'b01:   ext_data = uns_q ? {{(DATA_W-16){1'b0}}, rd_half}
                                   : {{(DATA_W-16){rd_half[15]}}, rd_half};
         default: ext_data = read_data;
      endcase
      if (size_q == 2'b00) merge_data[{off_q, 3'b000} +: 8]   = wdata_q[7:0];
      else                 merge_data[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // Next-state and next-output decode
   always_comb begin
      state_n      = state;
      off_n        = off_q;
      size_n       = size_q;
      uns_n        = uns_q;
      load_n       = load_q;
      wdata_n      = wdata_q;
      address_n    = address;
      write_data_n = write_data;
      load_data_n  = load_data;
      done_n       = 1'b0;
      load_valid_n = 1'b0;
      access_err_n = 1'b0;
      memwrite_n   = 1'b0;
      memread_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               address_n = req_addr[BA_W-1:2];
               off_n     = req_addr[1:0];
               size_n    = req_size;
               uns_n     = req_unsigned;
               load_n    = req_load;
               wdata_n   = req_wdata;
               if (req_illegal) begin
                  state_n      = S_FIN;
                  done_n       = 1'b1;
                  access_err_n = 1'b1;
               end else if (req_store && (req_size == 2'b10)) begin
                  state_n      = S_WR;
                  memwrite_n   = 1'b1;
                  write_data_n = req_wdata;
               end else begin
                  state_n   = S_RD;
                  memread_n = 1'b1;
               end
            end
         end
         S_RD: begin
            state_n = S_CAP;
         end
         S_CAP: begin
            if (load_q) begin
               load_data_n  = ext_data;
               load_valid_n = 1'b1;
               done_n       = 1'b1;
               state_n      = S_FIN;
            end else begin
               write_data_n = merge_data;
               memwrite_n   = 1'b1;
               state_n      = S_WR;
            end
         end
         S_WR: begin
            done_n  = 1'b1;
            state_n = S_FIN;
         end
         S_FIN: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
      busy_n = (state_n != S_IDLE);
   end

   // State, latched request and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         off_q           <= 2'b00;
         size_q          <= 2'b00;
         uns_q           <= 1'b0;
         load_q          <= 1'b0;
         wdata_q         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         load_valid      <= 1'b0;
         access_err      <= 1'b0;
         memwrite_enable <= 1'b0;
         memread_enable  <= 1'b0;
         address         <= '0;
         write_data      <= '0;
         load_data       <= '0;
      end else begin
         state           <= state_n;
         off_q           <= off_n;
         size_q          <= size_n;
         uns_q           <= uns_n;
         load_q          <= load_n;
         wdata_q         <= wdata_n;
         busy            <= busy_n;
         done            <= done_n;
         load_valid      <= load_valid_n;
         access_err      <= access_err_n;
         memwrite_enable <= memwrite_n;
         memread_enable  <= memread_n;
         address         <= address_n;
         write_data      <= write_data_n;
         load_data       <= load_data_n;
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a 1024x32 synchronous memory.
module tb_dmem_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_load, req_store, req_unsigned;
   logic [1:0]  req_size;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy, done, load_valid, access_err;
   logic        memwrite_enable, memread_enable;
   logic [9:0]  address;
   logic [31:0] write_data, read_data, load_data;

   logic [31:0] mem [0:1023];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [9:0]  wr_addr = '0;
   int          rd_base, wr_base;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] sb [$];

   dmem_access_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .busy(busy), .done(done), .load_valid(load_valid), .load_data(load_data),
      .access_err(access_err), .memwrite_enable(memwrite_enable),
      .memread_enable(memread_enable), .address(address),
      .write_data(write_data), .read_data(read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model plus access counters
   always @(posedge clk) begin
      if (memwrite_enable) begin
         mem[address] <= write_data;
         wr_cnt       <= wr_cnt + 1;
         wr_addr      <= address;
      end
      if (memread_enable) begin
         read_data <= mem[address];
         rd_cnt    <= rd_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Present one request for a single accept edge; returns #1 after that edge
   task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [11:0] a, input logic [31:0] wd);
      @(negedge clk);
      rd_base      = rd_cnt;
      wr_base      = wr_cnt;
      req_load     = ld;
      req_store    = st;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      req_valid    = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Wait for done (bounded), check latency/flags/data/accesses, then idle
   task automatic finish_req(input string tag, input int exp_lat, input logic exp_err,
                             input logic exp_lv, input int exp_rd, input int exp_wr);
      int lat;
      lat = 1;
      while (!done && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(access_err), 32'(exp_err));
      check({tag, "_lv"}, 32'(load_valid), 32'(exp_lv));
      if (exp_lv && sb.size() > 0) check({tag, "_data"}, load_data, sb.pop_front());
      check({tag, "_nrd"}, 32'(rd_cnt - rd_base), 32'(exp_rd));
      check({tag, "_nwr"}, 32'(wr_cnt - wr_base), 32'(exp_wr));
      @(posedge clk);
      #1;
      check({tag, "_idle"}, 32'({busy, done, load_valid, access_err}), 32'(0));
   endtask

   task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [31:0] exp);
      sb.push_back(exp);
      issue(1'b1, 1'b0, sz, uns, a, 32'h0);
      finish_req(tag, 3, 1'b0, 1'b1, 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", 32'({busy, done, load_valid, access_err, memwrite_enable, memread_enable}), 32'(0));
      check("rst_addr", 32'(address), 32'(0));
      check("rst_wd", write_data, 32'h0);
      check("rst_ld", load_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Word store then word load
      issue(1'b0, 1'b1, 2'b10, 1'b0, 12'h028, 32'hDEADBEEF);
      finish_req("wst", 2, 1'b0, 1'b0, 0, 1);
      check("wst_addr", 32'(wr_addr), 32'(10));
      load("wld", 2'b10, 1'b0, 12'h028, 32'hDEADBEEF);

      // Byte store (RMW) and loads
      issue(1'b0, 1'b1, 2'b00, 1'b0, 12'h029, 32'h123456A5);
      finish_req("bst", 4, 1'b0, 1'b0, 1, 1);
      load("bld_s", 2'b00, 1'b0, 12'h029, 32'hFFFFFFA5);
      load("bld_u", 2'b00, 1'b1, 12'h029, 32'h000000A5);
      load("bld_w", 2'b10, 1'b0, 12'h028, 32'hDEADA5EF);

      // Halfword store (RMW) and loads
      issue(1'b0, 1'b1, 2'b01, 1'b0, 12'h02A, 32'hCAFE8001);
      finish_req("hst", 4, 1'b0, 1'b0, 1, 1);
      load("hld_s", 2'b01, 1'b0, 12'h02A, 32'hFFFF8001);
      load("hld_u", 2'b01, 1'b1, 12'h02A, 32'h00008001);
      load("hld_w", 2'b10, 1'b0, 12'h028, 32'h8001A5EF);

      // Illegal requests
      issue(1'b1, 1'b0, 2'b10, 1'b0, 12'h029, 32'h0);
      finish_req("ill_wmis", 1, 1'b1, 1'b0, 0, 0);
      issue(1'b0, 1'b1, 2'b01, 1'b0, 12'h02B, 32'hFFFFFFFF);
      finish_req("ill_hmis", 1, 1'b1, 1'b0, 0, 0);
      issue(1'b1, 1'b0, 2'b11, 1'b0, 12'h028, 32'h0);
      finish_req("ill_sz3", 1, 1'b1, 1'b0, 0, 0);
      issue(1'b1, 1'b1, 2'b10, 1'b0, 12'h028, 32'h0);
      finish_req("ill_both", 1, 1'b1, 1'b0, 0, 0);
      check("ill_mem", mem[10], 32'h8001A5EF);

      // Reset while a byte store sits in CAP
      issue(1'b0, 1'b1, 2'b00, 1'b0, 12'h028, 32'h00000077);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_ctl", 32'({busy, done, load_valid, access_err, memwrite_enable, memread_enable}), 32'(0));
      check("mrst_addr", 32'(address), 32'(0));
      check("mrst_wd", write_data, 32'h0);
      check("mrst_ld", load_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("mrst_nwr", 32'(wr_cnt - wr_base), 32'(0));
      load("mrst_wld", 2'b10, 1'b0, 12'h028, 32'h8001A5EF);

      // Request held high while busy is ignored, then taken on the first IDLE edge
      sb.push_back(32'h8001A5EF);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 12'h028, 32'h0);
      req_size  = 2'b00;
      req_addr  = 12'h02B;
      req_valid = 1'b1;
      finish_req("hold1", 3, 1'b0, 1'b1, 1, 0);
      rd_base = rd_cnt;
      wr_base = wr_cnt;
      sb.push_back(32'hFFFFFF80);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("hold2_acc", 32'({busy, memread_enable}), 32'(3));
      finish_req("hold2", 3, 1'b0, 1'b1, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
